// File: rtl/axis_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pattern_gen
// Purpose  : AXI4-Stream video frame source with SOF/EOF/SOL/EOL tuser markers
//            and ramp / constant / walking-one / LFSR data patterns.
// Revision : 1.0
// ============================================================================
module axis_pattern_gen #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int LINE_CNT_WIDTH  = 16,
    parameter int GAP_CNT_WIDTH   = 8
) (
    input  logic                       aclk,
    input  logic                       aclk_reset_n,
    input  logic                       cfg_start,
    input  logic                       cfg_abort,
    input  logic [1:0]                 cfg_mode,
    input  logic [LINE_CNT_WIDTH-1:0]  cfg_beats_per_line,
    input  logic [LINE_CNT_WIDTH-1:0]  cfg_lines_per_frame,
    input  logic [7:0]                 cfg_frames,
    input  logic [GAP_CNT_WIDTH-1:0]   cfg_line_gap,
    input  logic [31:0]                cfg_seed,
    output logic                       busy,
    output logic                       cfg_err,
    output logic                       frame_done,
    output logic [15:0]                frame_count,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser
);
    localparam int              c_NB        = AXIS_DATA_WIDTH / 8;
    localparam int              c_WW        = $clog2(AXIS_DATA_WIDTH);
    localparam logic [c_WW-1:0] c_WALK_MAX  = c_WW'(AXIS_DATA_WIDTH - 1);
    localparam logic [7:0]      c_NB8       = 8'(c_NB);
    localparam logic [1:0]      c_MODE_RAMP = 2'd0;
    localparam logic [1:0]      c_MODE_CONST = 2'd1;
    localparam logic [1:0]      c_MODE_WALK = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LINE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_err;
    logic                       r_done;
    logic                       r_abort_pend;
    logic [15:0]                r_fcount;
    logic [1:0]                 r_mode;
    logic [31:0]                r_seed;
    logic [31:0]                r_lfsr;
    logic [LINE_CNT_WIDTH-1:0]  r_beats;
    logic [LINE_CNT_WIDTH-1:0]  r_lines;
    logic [LINE_CNT_WIDTH-1:0]  r_beat;
    logic [LINE_CNT_WIDTH-1:0]  r_line;
    logic [c_WW-1:0]            r_walk;
    logic [7:0]                 r_frames;
    logic [7:0]                 r_frames_left;
    logic [GAP_CNT_WIDTH-1:0]   r_gap;
    logic [GAP_CNT_WIDTH-1:0]   r_gap_cnt;

    logic                       w_hs;
    logic                       w_last_beat;
    logic                       w_last_line;
    logic                       w_more_frames;
    logic                       w_abort;
    logic [31:0]                w_lfsr_next;
    logic [7:0]                 w_ramp_base;
    logic [AXIS_DATA_WIDTH-1:0] w_data;
    logic [AXIS_USER_WIDTH-1:0] w_user;

    assign w_hs          = r_valid & m_axis_tready;
    assign w_last_beat   = (r_beat == r_beats - LINE_CNT_WIDTH'(1));
    assign w_last_line   = (r_line == r_lines - LINE_CNT_WIDTH'(1));
    assign w_more_frames = (r_frames == 8'd0) || (r_frames_left != 8'd1);
    assign w_abort       = cfg_abort | r_abort_pend;
    assign w_lfsr_next   = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            r_state       <= S_IDLE;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_fcount      <= '0;
            r_mode        <= '0;
            r_seed        <= '0;
            r_lfsr        <= '0;
            r_beats       <= '0;
            r_lines       <= '0;
            r_beat        <= '0;
            r_line        <= '0;
            r_walk        <= '0;
            r_frames      <= '0;
            r_frames_left <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort has priority over a coincident start.
                    if (cfg_start && !cfg_abort) begin
                        if (cfg_beats_per_line == '0 || cfg_lines_per_frame == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state       <= S_LINE;
                            r_valid       <= 1'b1;
                            r_busy        <= 1'b1;
                            r_abort_pend  <= 1'b0;
                            r_fcount      <= '0;
                            r_mode        <= cfg_mode;
                            r_seed        <= cfg_seed;
                            r_lfsr        <= (cfg_seed == 32'd0) ? 32'h1 : cfg_seed;
                            r_beats       <= cfg_beats_per_line;
                            r_lines       <= cfg_lines_per_frame;
                            r_beat        <= '0;
                            r_line        <= '0;
                            r_walk        <= '0;
                            r_frames      <= cfg_frames;
                            r_frames_left <= cfg_frames;
                            r_gap         <= cfg_line_gap;
                        end
                    end
                end
                S_LINE: begin
                    if (w_hs) begin
                        r_lfsr <= w_lfsr_next;
                        if (w_last_beat) begin
                            r_beat <= '0;
                            r_walk <= '0;
                            if (w_last_line) begin
                                r_line   <= '0;
                                r_done   <= 1'b1;
                                r_fcount <= r_fcount + 16'd1;
                                if (r_frames != 8'd0)
                                    r_frames_left <= r_frames_left - 8'd1;
                            end else begin
                                r_line <= r_line + LINE_CNT_WIDTH'(1);
                            end
                        end else begin
                            r_beat <= r_beat + LINE_CNT_WIDTH'(1);
                            r_walk <= (r_walk == c_WALK_MAX) ? '0 : r_walk + c_WW'(1);
                        end
                        if (w_abort || (w_last_beat && w_last_line && !w_more_frames)) begin
                            r_state      <= S_IDLE;
                            r_valid      <= 1'b0;
                            r_busy       <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end else if (w_last_beat && r_gap != '0) begin
                            r_state   <= S_GAP;
                            r_valid   <= 1'b0;
                            r_gap_cnt <= r_gap;
                        end
                    end else if (cfg_abort) begin
                        // Remember the abort until the stalled beat is taken.
                        r_abort_pend <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cfg_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap_cnt == GAP_CNT_WIDTH'(1)) begin
                        r_state <= S_LINE;
                        r_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_data      = '0;
        w_ramp_base = 8'(r_fcount) + 8'(r_line) + 8'(r_beat) * c_NB8;
        case (r_mode)
            c_MODE_RAMP: begin
                for (int k = 0; k < c_NB; k++)
                    w_data[8*k +: 8] = w_ramp_base + 8'(k);
            end
            c_MODE_CONST: begin
                for (int i = 0; i < AXIS_DATA_WIDTH; i++)
                    w_data[i] = r_seed[i[4:0]];
            end
            c_MODE_WALK: begin
                w_data[r_walk] = 1'b1;
            end
            default: begin
                for (int i = 0; i < AXIS_DATA_WIDTH; i++)
                    w_data[i] = r_lfsr[i[4:0]];
            end
        endcase
    end

    always_comb begin
        w_user    = '0;
        w_user[0] = (r_line == '0) && (r_beat == '0);
        w_user[1] = w_last_line && w_last_beat;
        w_user[2] = (r_beat == '0);
        w_user[3] = w_last_beat;
    end

    assign m_axis_tdata  = r_valid ? w_data : '0;
    assign m_axis_tuser  = r_valid ? w_user : '0;
    assign m_axis_tlast  = r_valid & w_last_beat;
    assign m_axis_tvalid = r_valid;
    assign busy          = r_busy;
    assign cfg_err       = r_err;
    assign frame_done    = r_done;
    assign frame_count   = r_fcount;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
`default_nettype none
// Bench for axis_pattern_gen: directed configurations with randomised ready and
// seeds, checked against a beat-list reference model built from the marker/pattern rules.
module tb_axis_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0, start_w = 1'b0, abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] bpl = '0, lpf = '0;
    logic [7:0]  frames = '0, gap = '0;
    logic [31:0] seed = '0;
    logic        tready = 1'b0, tready_w = 1'b0;

    logic        busy, err, fdone, tvalid, tlast;
    logic [15:0] fcount;
    logic [63:0] tdata;
    logic [3:0]  tuser;
    logic        busy_w, err_w, fdone_w, tvalid_w, tlast_w;
    logic [15:0] fcount_w;
    logic [255:0] tdata_w;
    logic [3:0]  tuser_w;

    axis_pattern_gen #(.AXIS_DATA_WIDTH(64)) u_dut (
        .aclk(clk), .aclk_reset_n(rst_n), .cfg_start(start), .cfg_abort(abort),
        .cfg_mode(mode), .cfg_beats_per_line(bpl), .cfg_lines_per_frame(lpf),
        .cfg_frames(frames), .cfg_line_gap(gap), .cfg_seed(seed),
        .busy(busy), .cfg_err(err), .frame_done(fdone), .frame_count(fcount),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser));

    axis_pattern_gen #(.AXIS_DATA_WIDTH(256)) u_dut_w (
        .aclk(clk), .aclk_reset_n(rst_n), .cfg_start(start_w), .cfg_abort(abort),
        .cfg_mode(mode), .cfg_beats_per_line(bpl), .cfg_lines_per_frame(lpf),
        .cfg_frames(frames), .cfg_line_gap(gap), .cfg_seed(seed),
        .busy(busy_w), .cfg_err(err_w), .frame_done(fdone_w), .frame_count(fcount_w),
        .m_axis_tdata(tdata_w), .m_axis_tvalid(tvalid_w), .m_axis_tready(tready_w),
        .m_axis_tlast(tlast_w), .m_axis_tuser(tuser_w));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    acc_cyc[$];
    int    fd_seen;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: every beat of F frames derived directly from (f, l, b).
    task automatic build(input int md, input int B, input int L, input int F, input logic [31:0] sd);
        beat_t       e;
        logic [31:0] lf;
        lf = (sd == 32'd0) ? 32'h1 : sd;
        exp_q.delete();
        for (int f = 0; f < F; f++)
            for (int l = 0; l < L; l++)
                for (int b = 0; b < B; b++) begin
                    case (md)
                        0: for (int k = 0; k < 8; k++) e.d[8*k +: 8] = 8'((f + l + b*8 + k) % 256);
                        1: e.d = {sd, sd};
                        2: e.d = 64'd1 << (b % 64);
                        default: begin
                            e.d = {lf, lf};
                            lf  = (lf << 1) | 32'(lf[31] ^ lf[21] ^ lf[1] ^ lf[0]);
                        end
                    endcase
                    e.u = {b == B-1, b == 0, (l == L-1) && (b == B-1), (l == 0) && (b == 0)};
                    e.l = (b == B-1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic start_run(input int md, input int B, input int L, input int F, input int g, input logic [31:0] sd);
        mode = 2'(md); bpl = 16'(B); lpf = 16'(L); frames = 8'(F); gap = 8'(g); seed = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consume nbeats beats (or until the budget expires), comparing with exp_q.
    task automatic run(input bit rnd, input int nbeats, input int budget);
        beat_t e;
        int    cyc = 0;
        int    n = 0;
        acc_cyc.delete();
        fd_seen = 0;
        while (n < nbeats && cyc < budget) begin
            tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (fdone) fd_seen++;
            if (tvalid && tready) begin
                e = exp_q.pop_front();
                chk($sformatf("beat%0d_data", n), tdata, e.d);
                chk($sformatf("beat%0d_user", n), tuser, e.u);
                chk($sformatf("beat%0d_last", n), tlast, e.l);
                acc_cyc.push_back(cyc);
                n++;
            end
            tick();
            cyc++;
        end
        if (fdone) fd_seen++;
        chk("run_beats_done", n, nbeats);
    endtask

    // Hold rule: a stalled beat must stay on the bus unchanged.
    logic        p_v, p_r, p_rst;
    logic [63:0] p_d;
    logic [3:0]  p_u;
    logic        p_l;
    initial begin p_v = 1'b0; p_r = 1'b0; p_rst = 1'b0; p_d = '0; p_u = '0; p_l = 1'b0; end
    always @(negedge clk) begin
        if (p_rst && rst_n && p_v && !p_r) begin
            chk("hold_valid", tvalid, 1'b1);
            chk("hold_data", tdata, p_d);
            chk("hold_user", {tlast, tuser}, {p_l, p_u});
        end
        p_rst = rst_n; p_v = tvalid; p_r = tready; p_d = tdata; p_u = tuser; p_l = tlast;
    end

    logic [255:0] one_hot;
    int           b;
    int           cyc;
    logic [31:0]  rseed;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_tuser", {tlast, tuser}, 5'd0);
        chk("rst_status", {busy, err, fdone}, 3'd0);
        chk("rst_fcount", fcount, 16'd0);
        rst_n = 1'b1;
        tick();

        // Ramp, B=4 L=2, ready always high
        tready = 1'b1;
        start_run(0, 4, 2, 1, 0, 32'd0);
        chk("t1_latency", {tvalid, busy}, 2'b11);
        chk("t1_beat0_user", tuser, 4'b0101);
        build(0, 4, 2, 1, 32'd0);
        chk("t1_model_beat1", exp_q[1].d, 64'h0F0E0D0C0B0A0908);
        run(0, 8, 50);
        chk("t1_back_to_back", acc_cyc[7] - acc_cyc[0], 7);
        chk("t1_frame_done", fd_seen, 1);
        chk("t1_end", {busy, tvalid}, 2'b00);
        chk("t1_fcount", fcount, 16'd1);

        // Same config with random stalls
        tready = 1'b0;
        start_run(0, 4, 2, 1, 0, 32'd0);
        build(0, 4, 2, 1, 32'd0);
        run(1, 8, 200);
        chk("t2_frame_done", fd_seen, 1);
        chk("t2_fcount", fcount, 16'd1);
        chk("t2_end", {busy, tvalid}, 2'b00);

        // LFSR, seed 0, gaps of 5, two frames
        tready = 1'b1;
        start_run(3, 3, 3, 2, 5, 32'd0);
        chk("t3_first_lfsr", tdata, {2{32'h1}});
        build(3, 3, 3, 2, 32'd0);
        run(0, 18, 300);
        for (int i = 1; i < 18; i++)
            chk($sformatf("t3_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], (i % 3 == 0) ? 6 : 1);
        chk("t3_fcount", fcount, 16'd2);
        chk("t3_frame_done", fd_seen, 2);
        chk("t3_end", busy, 1'b0);

        // Continuous constant run, aborted during a stall
        rseed = $urandom;
        start_run(1, 5, 2, 0, 1, rseed);
        build(1, 5, 2, 3, rseed);
        run(0, 22, 200);
        tready = 1'b0;
        chk("t4_still_busy", {busy, tvalid}, 2'b11);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_stalled_valid", tvalid, 1'b1);
        tick();
        tready = 1'b1;
        chk("t4_stalled_beat", tdata, exp_q[0].d);
        chk("t4_stalled_user", tuser, exp_q[0].u);
        tick();
        chk("t4_after_abort", {tvalid, busy, fdone}, 3'b000);
        chk("t4_frame_done", fd_seen, 2);
        chk("t4_fcount", fcount, 16'd2);
        tick();
        chk("t4_stays_idle", tvalid, 1'b0);

        // Zero size start rejected
        mode = 2'd0; bpl = 16'd0; lpf = 16'd2; frames = 8'd1; gap = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_err_pulse", {err, busy, tvalid}, 3'b100);
        tick();
        chk("t5_err_gone", {err, busy, tvalid}, 3'b000);
        bpl = 16'd3; lpf = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_err_lines", {err, busy}, 2'b10);

        // Abort and start together in idle: abort wins
        bpl = 16'd3; lpf = 16'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t6_abort_wins", {tvalid, busy, err}, 3'b000);

        // Start while busy is ignored
        tready = 1'b0;
        start_run(0, 2, 1, 1, 0, 32'd0);
        mode = 2'd1; bpl = 16'd7; lpf = 16'd5; seed = 32'hDEADBEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_no_err", err, 1'b0);
        build(0, 2, 1, 1, 32'd0);
        run(0, 2, 20);
        chk("t7_end", {busy, tvalid, fcount}, {2'b00, 16'd1});

        // 256-bit walking one, B=300, including wrap of the walking bit
        tready_w = 1'b1;
        mode = 2'd2; bpl = 16'd300; lpf = 16'd1; frames = 8'd1; gap = 8'd0;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        b = 0; cyc = 0;
        while (b < 300 && cyc < 400) begin
            if (tvalid_w && tready_w) begin
                one_hot = 256'd1 << (b % 256);
                if (b == 0 || b == 1 || b == 255 || b == 256 || b == 257 || b == 299)
                    chk($sformatf("w_beat%0d_data", b), tdata_w, one_hot);
                if (b == 0)   chk("w_beat0_user", {tlast_w, tuser_w}, 5'b00101);
                if (b == 299) chk("w_beat299_user", {tlast_w, tuser_w}, 5'b11010);
                b++;
            end
            tick();
            cyc++;
        end
        chk("w_beats", b, 300);
        chk("w_end", {busy_w, tvalid_w, fdone_w}, 3'b001);
        chk("w_beat257_bit1", (256'd1 << (257 % 256)), 256'd2);

        // Asynchronous reset at beat 100
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        b = 0; cyc = 0;
        while (b < 100 && cyc < 200) begin
            if (tvalid_w && tready_w) b++;
            tick();
            cyc++;
        end
        chk("w_reached_100", {b, tvalid_w}, {32'd100, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("w_async_valid", {tvalid_w, tlast_w, busy_w}, 3'b000);
        chk("w_async_data", tdata_w, 256'd0);
        chk("w_async_user", tuser_w, 4'd0);
        chk("w_async_fcount", fcount_w, 16'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("w_no_resume", {tvalid_w, busy_w}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
- Parametrised AXI4-Stream video source for the XGS validation environment.
- Generates complete image frames (lines × beats) with XGS-style tuser markers and a selectable data pattern.
- Drives the s_axis_tx input of the system under test, replacing bench-side stream driving.
- Generalises the fixed 64-bit/4-bit stream to any width and adds pattern modes, inter-line gaps, multi-frame runs and abort.

Parameters:
AXIS_DATA_WIDTH, 64, tdata width; multiple of 8, 32..256
AXIS_USER_WIDTH, 4, tuser width; >=4; bits above 3 driven 0
LINE_CNT_WIDTH, 16, width of beats-per-line and lines-per-frame counters
GAP_CNT_WIDTH, 8, width of inter-line idle counter

Ports:
aclk  in  1  clock
aclk_reset_n  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle pulse; latches cfg_* and starts a run
cfg_abort  in  1  single-cycle pulse; stop at next beat boundary
cfg_mode  in  2  0=ramp, 1=constant, 2=walking-one, 3=LFSR
cfg_beats_per_line  in  LINE_CNT_WIDTH  beats per line, must be >=1
cfg_lines_per_frame  in  LINE_CNT_WIDTH  lines per frame, must be >=1
cfg_frames  in  8  frames per run; 0 = continuous until abort
cfg_line_gap  in  GAP_CNT_WIDTH  idle cycles between lines (tvalid=0)
cfg_seed  in  32  constant value / LFSR seed
busy  out  1  run in progress
cfg_err  out  1  one-cycle pulse: start rejected (zero size)
frame_done  out  1  one-cycle pulse when the EOF beat is accepted
frame_count  out  16  frames completed since last start; wraps at 65535
m_axis_tdata  out  AXIS_DATA_WIDTH  pixel data
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tlast  out  1  last beat of each line
m_axis_tuser  out  AXIS_USER_WIDTH  [0]=SOF, [1]=EOF, [2]=SOL, [3]=EOL

Behaviour:
- Reset: every output is 0; state IDLE; LFSR holds 0.
- States:
  - IDLE: tvalid=0. On cfg_start with both sizes non-zero, latch config, clear counters and frame_count, load LFSR with cfg_seed (0 is replaced by 32'h1), go to LINE. busy=1 from the next cycle.
  - LINE: tvalid=1. A beat advances only on tvalid&tready.
  - GAP: tvalid=0 for cfg_line_gap cycles, then LINE. A gap of 0 skips GAP, giving back-to-back lines.
  - Frame end: after the last line's last beat, the next frame starts via GAP (gap applied) when frames remain or the run is continuous; otherwise go to IDLE and busy=0 the cycle after acceptance.
- Zero size: cfg_start with cfg_beats_per_line=0 or cfg_lines_per_frame=0 pulses cfg_err for 1 cycle and stays IDLE.
- cfg_start while busy: ignored (no error).
- Latency: first beat (tvalid=1) appears 1 cycle after cfg_start.
- AXI-S hold rule: while tvalid=1 and tready=0, tdata, tuser and tlast hold stable. tvalid never drops without a handshake, except on reset.
- Markers for beat b of line l (0-based), B = beats_per_line, L = lines_per_frame:
  - tlast = EOL = (b==B-1)
  - SOL = (b==0)
  - SOF = (l==0 & b==0)
  - EOF = (l==L-1 & b==B-1)
  - B=1: SOL, EOL and tlast are all set on the same beat.
- Patterns, with byte lane k and NB = AXIS_DATA_WIDTH/8:
  - ramp: byte k = (frame_count + l + b*NB + k) mod 256
  - constant: cfg_seed replicated across the bus
  - walking-one: only bit (b mod AXIS_DATA_WIDTH) set
  - LFSR: 32-bit Fibonacci, taps 32,22,2,1. Advances once per accepted beat; the current value is replicated. Not reset between frames.
- frame_done: pulses with each EOF handshake. frame_count increments on the same edge.
- cfg_abort:
  - If tvalid=0 (IDLE/GAP): go to IDLE next cycle.
  - If tvalid=1: complete the pending handshake, then go to IDLE; tvalid=0 the cycle after acceptance.
  - No frame_done unless the aborted beat was EOF.
  - Simultaneous abort and start in IDLE: abort wins; start is ignored.
- Async reset mid-frame: outputs clear immediately; there is no resume.

Test Plan:
- DATA=64, mode 0, B=4, L=2, frames=1, gap=0, tready=1 -> 8 beats on consecutive cycles; beat0 tuser=4'b0101, beat3 tuser=4'b1000 with tlast, beat7 tuser=4'b1010 with tlast; beat1 tdata=64'h0F0E0D0C0B0A0908; one frame_done; busy low after the 8th beat.
- Same config with tready toggling 1-0-0-1 pseudo-randomly -> no tdata/tuser change while stalled; identical 8-beat sequence; SVA hold check passes.
- mode 3, seed 0, B=3, L=3, gap=5, frames=2 -> LFSR starts at 32'h1; exactly 5 idle cycles between lines and between frames; 18 beats; frame_count=2.
- Continuous run (frames=0), abort asserted during a tready=0 stall mid-line -> stalled beat is accepted once, then tvalid=0, busy=0; frame_done count equals completed frames only.
- cfg_start with B=0 -> cfg_err pulse, busy stays 0, no tvalid; cfg_start during busy -> ignored, running config unchanged.
- DATA=256, mode 2, B=300, L=1 -> beat 257 has bit 1 set; wrap of the walking bit verified; reset asserted at beat 100 clears all outputs asynchronously.
